// File: rtl/vram_tile_write_ctrl_if.sv
// MCU pixel-pair write channel (valid/ready) into the VRAM tile write controller.
interface vram_tile_write_ctrl_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/vram_tile_write_ctrl.sv
// VRAM tile memory write-port owner: MCU write FIFO drained during vblank,
// plus a full-memory fill engine.
// Optional macro VRAM_TILE_WRITE_VBLANK_GATE_EN: when defined, pops and fill
// writes only happen while vblank is high; otherwise they run at full rate.
module vram_tile_write_ctrl #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          vblank,
  vram_tile_write_ctrl_if.slave         wr,
  input  logic                          fill_start,
  input  logic [DATA_W-1:0]             fill_value,
  output logic                          fill_busy,
  output logic                          fill_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          mem_write_enable,
  output logic [ADDR_W-1:0]             mem_write_addr,
  output logic [DATA_W-1:0]             mem_write_data
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, FILL} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  state_t            state_q, state_d;
  wr_req_t           fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [ADDR_W-1:0] fill_cnt;
  logic [DATA_W-1:0] fill_val_q;
  logic              fill_pending_q, fill_busy_q, fill_last_q, fill_done_q;
  logic              wr_ready_q, wr_ready_d;
  logic              gate, push, pop, fill_acc, fill_issue, fill_last;

`ifdef VRAM_TILE_WRITE_VBLANK_GATE_EN
  assign gate = vblank;
`else
  logic vblank_unused;
  assign vblank_unused = vblank;
  assign gate = 1'b1;
`endif

  assign push     = wr.wr_valid & wr_ready_q;
  assign fill_acc = fill_start & ~fill_busy_q;
  assign level_d  = level_q + LVL_W'(push) - LVL_W'(pop);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: a fill only starts once every previously queued MCU write has drained
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fill_acc && level_q == '0) state_d = FILL;
        else if (level_q != '0)        state_d = DRAIN;
      end
      DRAIN: begin
        if (level_q == '0) state_d = (fill_pending_q || fill_acc) ? FILL : IDLE;
      end
      FILL: begin
        if (fill_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; ready stays low through the final fill write cycle
  always_comb begin
    pop        = (state_q == DRAIN) && (level_q != '0) && gate;
    fill_issue = (state_q == FILL) && gate;
    fill_last  = fill_issue && (&fill_cnt);
    wr_ready_d = (level_d != LVL_W'(FIFO_DEPTH)) && (state_d != FILL) && !fill_last;
  end

  // FIFO storage (data needs no reset; validity is tracked by level)
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{addr: wr.wr_addr, data: wr.wr_data};
  end

  // FIFO pointers, occupancy and registered ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level_q    <= '0;
      wr_ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level_q    <= level_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  // Fill engine: value capture, pending latch, address counter, busy/done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_val_q     <= '0;
      fill_pending_q <= 1'b0;
      fill_busy_q    <= 1'b0;
      fill_last_q    <= 1'b0;
      fill_done_q    <= 1'b0;
      fill_cnt       <= '0;
    end else begin
      if (fill_acc) fill_val_q <= fill_value;
      fill_pending_q <= (state_d == FILL) ? 1'b0 : (fill_pending_q | fill_acc);
      if (fill_acc)         fill_busy_q <= 1'b1;
      else if (fill_last_q) fill_busy_q <= 1'b0;
      if (fill_issue) fill_cnt <= fill_cnt + 1'b1;
      fill_last_q <= fill_last;
      fill_done_q <= fill_last_q;
    end
  end

  // Registered memory write port; addr/data hold while enable is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_write_enable <= 1'b0;
      mem_write_addr   <= '0;
      mem_write_data   <= '0;
    end else begin
      mem_write_enable <= pop | fill_issue;
      if (pop) begin
        mem_write_addr <= fifo_mem[rd_ptr].addr;
        mem_write_data <= fifo_mem[rd_ptr].data;
      end else if (fill_issue) begin
        mem_write_addr <= fill_cnt;
        mem_write_data <= fill_val_q;
      end
    end
  end

  assign wr.wr_ready = wr_ready_q;
  assign fill_busy   = fill_busy_q;
  assign fill_done   = fill_done_q;
  assign fifo_level  = level_q;
endmodule

// File: tb/tb_vram_tile_write_ctrl.sv
// Directed bench for vram_tile_write_ctrl: single write, backpressure, gating,
// fill, fill behind queued writes, reset mid-fill.
module tb_vram_tile_write_ctrl;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int NFILL  = 32768;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              vblank = 1'b0;
  logic              fill_start = 1'b0;
  logic [DATA_W-1:0] fill_value = '0;
  logic              fill_busy, fill_done, mem_write_enable;
  logic [3:0]        fifo_level;
  logic [ADDR_W-1:0] mem_write_addr;
  logic [DATA_W-1:0] mem_write_data;

  vram_tile_write_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wr_if ();

  vram_tile_write_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n), .vblank(vblank), .wr(wr_if),
    .fill_start(fill_start), .fill_value(fill_value),
    .fill_busy(fill_busy), .fill_done(fill_done), .fifo_level(fifo_level),
    .mem_write_enable(mem_write_enable), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int acc_cyc;

  // Write monitor, sampled on the falling edge
  int wa[$];
  int wd[$];
  int wc[$];
  int done_cnt = 0, done_cyc = 0, rdy_busy_cnt = 0;
  always @(negedge clk) begin
    if (mem_write_enable) begin
      wa.push_back(int'(mem_write_addr));
      wd.push_back(int'(mem_write_data));
      wc.push_back(cyc);
    end
    if (fill_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (fill_busy && wr_if.wr_ready) rdy_busy_cnt <= rdy_busy_cnt + 1;
  end

  initial begin
    wr_if.wr_valid = 1'b0;
    wr_if.wr_addr  = '0;
    wr_if.wr_data  = '0;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int n = 0;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = a;
    wr_if.wr_data  = d;
    @(negedge clk);
    while (!wr_if.wr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (wr_if.wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL push_timeout addr=%h got_ready=%b want=1", a, wr_if.wr_ready);
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic pulse_fill(input logic [DATA_W-1:0] v);
    fill_value = v;
    fill_start = 1'b1;
    @(posedge clk);
    #1;
    fill_start = 1'b0;
    fill_value = ~v;
  endtask

  task automatic wait_done(input int d0, input string tag);
    int k = 0;
    while (done_cnt == d0 && k < 34000) begin
      @(negedge clk);
      #1;
      k++;
    end
    total++;
    if (done_cnt == d0) begin
      bad++;
      $display("FAIL %s_done_timeout got_done=%0d want>%0d", tag, done_cnt, d0);
    end
  endtask

  task automatic test_reset();
    #12;
    total += 7;
    if (mem_write_enable !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", mem_write_enable); end
    if (mem_write_addr !== '0) begin bad++; $display("FAIL rst_addr got=%h want=0", mem_write_addr); end
    if (mem_write_data !== '0) begin bad++; $display("FAIL rst_data got=%h want=0", mem_write_data); end
    if (fill_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", fill_busy); end
    if (fill_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", fill_done); end
    if (fifo_level !== 4'd0) begin bad++; $display("FAIL rst_level got=%0d want=0", fifo_level); end
    if (wr_if.wr_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", wr_if.wr_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (wr_if.wr_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after got=%b want=1", wr_if.wr_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_write();
    int i0, n;
    vblank = 1'b1;
    i0 = wa.size();
    push(15'h0010, 16'hABCD);
    wait_cyc(8);
    n = wa.size() - i0;
    total += 4;
    if (n != 1) begin bad++; $display("FAIL single_count got=%0d want=1", n); end
    if (n >= 1) begin
      total += 3;
      if (wa[i0] != 'h10) begin bad++; $display("FAIL single_addr got=%h want=0010", wa[i0]); end
      if (wd[i0] != 'hABCD) begin bad++; $display("FAIL single_data got=%h want=abcd", wd[i0]); end
      if (wc[i0] != acc_cyc + 2) begin bad++; $display("FAIL single_latency got=%0d want=%0d", wc[i0] - acc_cyc, 2); end
    end
    if (fifo_level !== 4'd0) begin bad++; $display("FAIL single_level got=%0d want=0", fifo_level); end
    if (mem_write_enable !== 1'b0) begin bad++; $display("FAIL single_we_low got=%b want=0", mem_write_enable); end
    if (mem_write_addr !== 15'h0010) begin bad++; $display("FAIL single_addr_hold got=%h want=0010", mem_write_addr); end
  endtask

  task automatic test_backpressure();
    int i0, n, err;
    i0 = wa.size();
`ifdef VRAM_TILE_WRITE_VBLANK_GATE_EN
    vblank = 1'b0;
    for (int i = 0; i < 8; i++) push(15'(16'h0100 + i), 16'(16'h1000 + i * 16'h11));
    @(negedge clk);
    total += 2;
    if (wr_if.wr_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b want=0", wr_if.wr_ready); end
    if (fifo_level !== 4'd8) begin bad++; $display("FAIL bp_level_full got=%0d want=8", fifo_level); end
    @(posedge clk);
    #1;
    vblank = 1'b1;
    push(15'h0108, 16'h1088);
`else
    vblank = 1'b1;
    for (int i = 0; i < 9; i++) push(15'(16'h0100 + i), 16'(16'h1000 + i * 16'h11));
    total++;
    if (fifo_level !== 4'd2) begin bad++; $display("FAIL bp_level_steady got=%0d want=2", fifo_level); end
`endif
    wait_cyc(20);
    n = wa.size() - i0;
    err = 0;
    if (n == 9)
      for (int i = 0; i < 9; i++) begin
        if (wa[i0+i] != 'h100 + i || wd[i0+i] != 'h1000 + i * 'h11) err++;
        if (i > 0 && wc[i0+i] != wc[i0+i-1] + 1) err++;
      end
    total += 3;
    if (n != 9) begin bad++; $display("FAIL bp_count got=%0d want=9", n); end
    if (err != 0) begin bad++; $display("FAIL bp_order got_errors=%0d want=0", err); end
    if (fifo_level !== 4'd0) begin bad++; $display("FAIL bp_level_end got=%0d want=0", fifo_level); end
  endtask

  task automatic test_vblank_gating();
    int i0, n, err;
    i0 = wa.size();
`ifdef VRAM_TILE_WRITE_VBLANK_GATE_EN
    vblank = 1'b0;
    for (int i = 0; i < 4; i++) push(15'(16'h0300 + i), 16'(16'h3300 + i));
    vblank = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    vblank = 1'b0;
    wait_cyc(6);
    n = wa.size() - i0;
    total += 3;
    if (n != 2) begin bad++; $display("FAIL gate_partial got=%0d want=2", n); end
    if (mem_write_enable !== 1'b0) begin bad++; $display("FAIL gate_hold_we got=%b want=0", mem_write_enable); end
    if (fifo_level !== 4'd2) begin bad++; $display("FAIL gate_hold_level got=%0d want=2", fifo_level); end
    vblank = 1'b1;
`else
    vblank = 1'b0;
    for (int i = 0; i < 4; i++) push(15'(16'h0300 + i), 16'(16'h3300 + i));
`endif
    wait_cyc(10);
    n = wa.size() - i0;
    err = 0;
    if (n == 4)
      for (int i = 0; i < 4; i++) begin
        if (wa[i0+i] != 'h300 + i || wd[i0+i] != 'h3300 + i) err++;
`ifndef VRAM_TILE_WRITE_VBLANK_GATE_EN
        if (i > 0 && wc[i0+i] != wc[i0+i-1] + 1) err++;
`endif
      end
    total += 3;
    if (n != 4) begin bad++; $display("FAIL gate_count got=%0d want=4", n); end
    if (err != 0) begin bad++; $display("FAIL gate_order got_errors=%0d want=0", err); end
    if (mem_write_addr !== 15'h0303) begin bad++; $display("FAIL gate_addr_hold got=%h want=0303", mem_write_addr); end
    vblank = 1'b1;
  endtask

  // Checks one complete fill run starting at queue index i0
  task automatic check_fill_seq(input int i0, input int exp_val, input string tag);
    int n, err, first;
    n = wa.size() - i0;
    err = 0;
    first = -1;
    if (n == NFILL)
      for (int k = 0; k < NFILL; k++)
        if (wa[i0+k] != k || wd[i0+k] != exp_val || (k > 0 && wc[i0+k] != wc[i0+k-1] + 1)) begin
          err++;
          if (first < 0) first = k;
        end
    total += 3;
    if (n != NFILL) begin bad++; $display("FAIL %s_fill_count got=%0d want=%0d", tag, n, NFILL); end
    if (err != 0) begin bad++; $display("FAIL %s_fill_seq got_errors=%0d first_idx=%0d want=0", tag, err, first); end
    if (n == NFILL && done_cyc != wc[i0+NFILL-1] + 1) begin
      bad++; $display("FAIL %s_done_timing got=%0d want=%0d", tag, done_cyc, wc[i0+NFILL-1] + 1);
    end
  endtask

  task automatic test_fill();
    int i0, d0, r0;
    vblank = 1'b1;
    i0 = wa.size();
    d0 = done_cnt;
    r0 = rdy_busy_cnt;
    pulse_fill(16'h0000);
    @(negedge clk);
    total += 2;
    if (fill_busy !== 1'b1) begin bad++; $display("FAIL fill_busy_start got=%b want=1", fill_busy); end
    if (wr_if.wr_ready !== 1'b0) begin bad++; $display("FAIL fill_ready_start got=%b want=0", wr_if.wr_ready); end
    wait_done(d0, "fill");
    wait_cyc(4);
    check_fill_seq(i0, 0, "fill");
    total += 4;
    if (done_cnt - d0 != 1) begin bad++; $display("FAIL fill_done_count got=%0d want=1", done_cnt - d0); end
    if (rdy_busy_cnt != r0) begin bad++; $display("FAIL fill_ready_low got=%0d want=%0d", rdy_busy_cnt, r0); end
    if (fill_busy !== 1'b0) begin bad++; $display("FAIL fill_busy_end got=%b want=0", fill_busy); end
    if (wr_if.wr_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_end got=%b want=1", wr_if.wr_ready); end
  endtask

  task automatic test_fill_after_pending();
    int i0, d0, n, err;
    vblank = 1'b1;
    i0 = wa.size();
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) push(15'(16'h0200 + i), 16'(16'hC000 + i));
    pulse_fill(16'h1234);
    @(negedge clk);
    total++;
    if (fill_busy !== 1'b1) begin bad++; $display("FAIL pend_busy got=%b want=1", fill_busy); end
    wait_cyc(100);
    pulse_fill(16'h5555);
    wait_done(d0, "pend");
    wait_cyc(40);
    n = wa.size() - i0;
    err = 0;
    if (n >= 3)
      for (int i = 0; i < 3; i++)
        if (wa[i0+i] != 'h200 + i || wd[i0+i] != 'hC000 + i) err++;
    total += 3;
    if (n != NFILL + 3) begin bad++; $display("FAIL pend_count got=%0d want=%0d", n, NFILL + 3); end
    if (err != 0) begin bad++; $display("FAIL pend_mcu_first got_errors=%0d want=0", err); end
    if (done_cnt - d0 != 1) begin bad++; $display("FAIL pend_done_count got=%0d want=1", done_cnt - d0); end
    if (n == NFILL + 3) check_fill_seq(i0 + 3, 'h1234, "pend");
  endtask

  task automatic test_reset_mid_fill();
    int d0, i0, k;
    vblank = 1'b1;
    d0 = done_cnt;
    pulse_fill(16'h7777);
    k = 0;
    @(negedge clk);
    while (!(mem_write_enable && mem_write_addr == 15'd1000) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (mem_write_addr !== 15'd1000) begin bad++; $display("FAIL rmf_reach got=%0d want=1000", mem_write_addr); end
    #2;
    rst_n = 1'b0;
    #1;
    total += 6;
    if (mem_write_enable !== 1'b0) begin bad++; $display("FAIL rmf_we got=%b want=0", mem_write_enable); end
    if (mem_write_addr !== '0) begin bad++; $display("FAIL rmf_addr got=%h want=0", mem_write_addr); end
    if (mem_write_data !== '0) begin bad++; $display("FAIL rmf_data got=%h want=0", mem_write_data); end
    if (fill_busy !== 1'b0) begin bad++; $display("FAIL rmf_busy got=%b want=0", fill_busy); end
    if (wr_if.wr_ready !== 1'b0) begin bad++; $display("FAIL rmf_ready got=%b want=0", wr_if.wr_ready); end
    if (fifo_level !== 4'd0) begin bad++; $display("FAIL rmf_level got=%0d want=0", fifo_level); end
    @(negedge clk);
    rst_n = 1'b1;
    i0 = wa.size();
    wait_cyc(12);
    total += 4;
    if (wa.size() != i0) begin bad++; $display("FAIL rmf_idle_writes got=%0d want=0", wa.size() - i0); end
    if (done_cnt != d0) begin bad++; $display("FAIL rmf_no_done got=%0d want=%0d", done_cnt, d0); end
    if (fill_busy !== 1'b0) begin bad++; $display("FAIL rmf_busy_after got=%b want=0", fill_busy); end
    if (wr_if.wr_ready !== 1'b1) begin bad++; $display("FAIL rmf_ready_after got=%b want=1", wr_if.wr_ready); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_backpressure();
    test_vblank_gating();
    test_fill();
    test_fill_after_pending();
    test_reset_mid_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
